// File: rtl/traffic_light.sv
// traffic_light: main/side road intersection controller with optional pedestrian walk phase.
//
// A Moore FSM steps MAIN_GREEN -> MAIN_YELLOW -> [WALK] -> SIDE_GREEN -> SIDE_YELLOW.
// Phase timing is counted in one-second ticks produced by a clock prescaler.
//
// Optional feature: define TRAFFIC_LIGHT_WALK_EN to build the WALK state and the walk latch.
// Without it, WalkButton is ignored and WalkLight is tied low.
//
// Parameters:
//   TICK_DIV  clock cycles per one-second tick (>= 1)
//   T_BASE    base green segment, seconds
//   T_EXT     sensor-dependent green segment, seconds
//   T_YEL     yellow duration, seconds
//   T_WALK    walk phase duration, seconds
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous active-high reset
//   Sensor      side-road vehicle present, sampled at segment-end ticks
//   WalkButton  pedestrian request, sampled every clock
//   MainGreen/MainYellow/MainRed  main-road lamps, one-hot
//   SideGreen/SideYellow/SideRed  side-road lamps, one-hot
//   WalkLight   pedestrian walk lamp
module traffic_light #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Sensor,
  input  logic WalkButton,
  output logic MainGreen,
  output logic MainYellow,
  output logic MainRed,
  output logic SideGreen,
  output logic SideYellow,
  output logic SideRed,
  output logic WalkLight
);

  // Widths sized for the largest count each counter must hold.
  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMaxGrn = (T_BASE > T_EXT) ? T_BASE : T_EXT;
  localparam int unsigned TMaxAux = (T_YEL > T_WALK) ? T_YEL : T_WALK;
  localparam int unsigned TMax    = (TMaxGrn > TMaxAux) ? TMaxGrn : TMaxAux;
  localparam int unsigned SW      = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] LastBase  = SW'(T_BASE - 1);
  localparam logic [SW-1:0] LastExt   = SW'(T_EXT - 1);
  localparam logic [SW-1:0] LastYel   = SW'(T_YEL - 1);
`ifdef TRAFFIC_LIGHT_WALK_EN
  localparam logic [SW-1:0] LastWalk  = SW'(T_WALK - 1);
`endif

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
`ifdef TRAFFIC_LIGHT_WALK_EN
    StWalk       = 3'd2,
`endif
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4
  } state_e;

  // Green segment: first base segment, then either the short (sensor) or long extension.
  typedef enum logic [1:0] {
    SegFirst = 2'd0,
    SegExt   = 2'd1,
    SegBase  = 2'd2
  } seg_e;

  state_e          state_q, state_d;
  seg_e            seg_q, seg_d;
  logic [SW-1:0]   sec_q, sec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [SW-1:0]   last;
  logic            go_walk;

  // ---------------------------------------------------------------------------
  // Prescaler: one tick every TICK_DIV clocks. State only changes on a tick, so the
  // prescaler is always at zero when a new phase starts.
  // ---------------------------------------------------------------------------
  assign tick = (presc_q == PrescLast);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // ---------------------------------------------------------------------------
  // Walk request latch
  // ---------------------------------------------------------------------------
`ifdef TRAFFIC_LIGHT_WALK_EN
  logic walk_q, walk_d;

  // A press on the deciding edge itself still counts.
  assign go_walk = walk_q | WalkButton;

  always_comb begin
    walk_d = walk_q;
    if (WalkButton && (state_q != StWalk)) begin
      walk_d = 1'b1;
    end
    // Entry into WALK consumes the request, including any press on that same edge.
    if ((state_d == StWalk) && (state_q != StWalk)) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      walk_q <= 1'b0;
    end else begin
      walk_q <= walk_d;
    end
  end
`else
  logic unused_walk_button;
  assign unused_walk_button = WalkButton;
  assign go_walk = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Duration of the current segment, expressed as its last second index.
  // ---------------------------------------------------------------------------
  always_comb begin
    last = LastBase;
    unique case (state_q)
      StMainGreen:  last = (seg_q == SegExt) ? LastExt : LastBase;
      StMainYellow: last = LastYel;
`ifdef TRAFFIC_LIGHT_WALK_EN
      StWalk:       last = LastWalk;
`endif
      StSideGreen:  last = (seg_q == SegExt) ? LastExt : LastBase;
      StSideYellow: last = LastYel;
      default:      last = LastBase;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    sec_d   = sec_q;
    if (tick) begin
      if (sec_q == last) begin
        // Segment complete: second counter restarts for whatever comes next.
        sec_d = '0;
        unique case (state_q)
          StMainGreen: begin
            if (seg_q == SegFirst) begin
              seg_d = Sensor ? SegExt : SegBase;
            end else begin
              state_d = StMainYellow;
              seg_d   = SegFirst;
            end
          end
          StMainYellow: begin
`ifdef TRAFFIC_LIGHT_WALK_EN
            state_d = go_walk ? StWalk : StSideGreen;
`else
            state_d = StSideGreen;
`endif
            seg_d = SegFirst;
          end
`ifdef TRAFFIC_LIGHT_WALK_EN
          StWalk: begin
            state_d = StSideGreen;
            seg_d   = SegFirst;
          end
`endif
          StSideGreen: begin
            if ((seg_q == SegFirst) && Sensor) begin
              seg_d = SegExt;
            end else begin
              state_d = StSideYellow;
              seg_d   = SegFirst;
            end
          end
          StSideYellow: begin
            state_d = StMainGreen;
            seg_d   = SegFirst;
          end
          default: begin
            state_d = StMainGreen;
            seg_d   = SegFirst;
          end
        endcase
      end else begin
        sec_d = sec_q + SW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StMainGreen;
      seg_q   <= SegFirst;
      sec_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    MainGreen  = 1'b0;
    MainYellow = 1'b0;
    MainRed    = 1'b0;
    SideGreen  = 1'b0;
    SideYellow = 1'b0;
    SideRed    = 1'b0;
    WalkLight  = 1'b0;
    unique case (state_q)
      StMainGreen: begin
        MainGreen = 1'b1;
        SideRed   = 1'b1;
      end
      StMainYellow: begin
        MainYellow = 1'b1;
        SideRed    = 1'b1;
      end
`ifdef TRAFFIC_LIGHT_WALK_EN
      StWalk: begin
        MainRed   = 1'b1;
        SideRed   = 1'b1;
        WalkLight = 1'b1;
      end
`endif
      StSideGreen: begin
        MainRed   = 1'b1;
        SideGreen = 1'b1;
      end
      StSideYellow: begin
        MainRed    = 1'b1;
        SideYellow = 1'b1;
      end
      default: begin
        MainGreen = 1'b1;
        SideRed   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: self-checking bench for traffic_light.
// Lamp outputs are compared every cycle against a phase/remaining-time model of the
// intersection rules. Works with or without TRAFFIC_LIGHT_WALK_EN defined.
module tb_traffic_light;

  localparam int unsigned TD = 1;
  localparam int unsigned TB = 6;
  localparam int unsigned TE = 3;
  localparam int unsigned TY = 2;
  localparam int unsigned TW = 3;

`ifdef TRAFFIC_LIGHT_WALK_EN
  localparam bit WalkEn = 1'b1;
`else
  localparam bit WalkEn = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Sensor = 1'b0;
  logic WalkButton = 1'b0;
  logic MainGreen, MainYellow, MainRed, SideGreen, SideYellow, SideRed, WalkLight;
  logic [6:0] lamps;

  int checks = 0;
  int errors = 0;

  typedef enum int {PhMainGreen, PhMainYellow, PhWalk, PhSideGreen, PhSideYellow} phase_t;
  phase_t m_phase;
  int     m_rem;       // cycles left in the current segment
  bit     m_second;    // green is in its second segment
  bit     m_walk;      // pending pedestrian request

  traffic_light #(
    .TICK_DIV(TD),
    .T_BASE  (TB),
    .T_EXT   (TE),
    .T_YEL   (TY),
    .T_WALK  (TW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Sensor    (Sensor),
    .WalkButton(WalkButton),
    .MainGreen (MainGreen),
    .MainYellow(MainYellow),
    .MainRed   (MainRed),
    .SideGreen (SideGreen),
    .SideYellow(SideYellow),
    .SideRed   (SideRed),
    .WalkLight (WalkLight)
  );

  always #5 Clk = ~Clk;

  assign lamps = {MainGreen, MainYellow, MainRed, SideGreen, SideYellow, SideRed, WalkLight};

  // {MG, MY, MR, SG, SY, SR, WL}
  function automatic logic [6:0] lamps_for(input phase_t p);
    case (p)
      PhMainGreen:  return 7'b1000010;
      PhMainYellow: return 7'b0100010;
      PhWalk:       return 7'b0010011;
      PhSideGreen:  return 7'b0011000;
      default:      return 7'b0010100;
    endcase
  endfunction

  task automatic model_reset();
    m_phase  = PhMainGreen;
    m_rem    = TB * TD;
    m_second = 1'b0;
    m_walk   = 1'b0;
  endtask

  // Apply one clock edge to the model with the inputs present at that edge.
  task automatic model_edge(input logic s, input logic b);
    if (WalkEn && b && m_phase != PhWalk) m_walk = 1'b1;
    m_rem--;
    if (m_rem == 0) begin
      case (m_phase)
        PhMainGreen: begin
          if (!m_second) begin
            m_second = 1'b1;
            m_rem    = (s ? TE : TB) * TD;
          end else begin
            m_phase = PhMainYellow;
            m_rem   = TY * TD;
          end
        end
        PhMainYellow: begin
          if (WalkEn && m_walk) begin
            m_phase = PhWalk;
            m_rem   = TW * TD;
            m_walk  = 1'b0;
          end else begin
            m_phase  = PhSideGreen;
            m_rem    = TB * TD;
            m_second = 1'b0;
          end
        end
        PhWalk: begin
          m_phase  = PhSideGreen;
          m_rem    = TB * TD;
          m_second = 1'b0;
        end
        PhSideGreen: begin
          if (!m_second && s) begin
            m_second = 1'b1;
            m_rem    = TE * TD;
          end else begin
            m_phase = PhSideYellow;
            m_rem   = TY * TD;
          end
        end
        default: begin
          m_phase  = PhMainGreen;
          m_rem    = TB * TD;
          m_second = 1'b0;
        end
      endcase
    end
  endtask

  task automatic check(input string tag);
    logic [6:0] exp;
    exp = lamps_for(m_phase);
    checks++;
    assert (lamps === exp)
    else begin
      errors++;
      $error("FAIL %s: lamps observed=%b expected=%b", tag, lamps, exp);
    end
  endtask

  // One clock: drive inputs, advance on the edge, sample 1 time unit later.
  task automatic step(input logic s, input logic b, input string tag);
    Sensor     = s;
    WalkButton = b;
    @(posedge Clk);
    model_edge(s, b);
    #1;
    check(tag);
  endtask

  // Asynchronous reset pulse applied mid-cycle, held across one edge.
  task automatic do_reset(input string tag);
    Sensor     = 1'b0;
    WalkButton = 1'b0;
    Reset      = 1'b1;
    #1;
    model_reset();
    check({tag, "_async"});
    @(posedge Clk);
    #1;
    check({tag, "_hold"});
    Reset = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    @(posedge Clk);
    #1;
    model_reset();
    check("reset");
    Reset = 1'b0;

    // Plain cycle, no sensor, no requests: 12/2/6/2.
    for (int i = 1; i <= 44; i++) step(1'b0, 1'b0, "base_cycle");

    // Single walk pulse at cycle 50.
    do_reset("rst_walk");
    for (int i = 1; i <= 80; i++) step(1'b0, i == 50, "walk_pulse");

    // Sensor held high: 9/2/9/2.
    do_reset("rst_sensor");
    for (int i = 1; i <= 60; i++) step(1'b1, 1'b0, "sensor_high");

    // Walk at 100, sensor from 110.
    do_reset("rst_mix");
    for (int i = 1; i <= 160; i++) step(i >= 110, i == 100, "walk_sensor");

    // Reset mid SIDE_GREEN with a request pending; it must be discarded.
    do_reset("rst_pre");
    for (int i = 0; i < 40 && m_phase != PhSideGreen; i++) step(1'b0, 1'b0, "to_side");
    step(1'b0, 1'b1, "press_side");
    step(1'b0, 1'b0, "side_hold");
    do_reset("rst_mid_side");
    for (int i = 1; i <= 30; i++) step(1'b0, 1'b0, "post_reset");

    // Random sensor and sparse presses, with an occasional async reset.
    do_reset("rst_rand");
    for (int i = 1; i <= 500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
